if_id_skid_stage: RTL and testbench

- Parametrised successor to the single-entry IF/ID pipeline register.
- Carries a multi-lane fetch packet (PC, instructions, per-lane valid, fault) from fetch to decode using a valid/ready handshake.
- Holds packets in a 2-entry skid buffer, so upstream ready is a registered signal and no combinational ready path runs back into fetch.
- Adds flush, NOP injection on empty lanes, PC-alignment fault tagging and a saturating backpressure counter.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/sat_counter.sv | 25 ++
 rtl/if_id_skid_stage.sv | 133 +++++++++++++
 tb/tb_if_id_skid_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch/decode pipeline stages.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_ILEN  = 32;
  localparam int DEF_LANES = 1;

  // Stages with non-default widths declare a local struct with this layout
  typedef struct packed {
    logic [DEF_XLEN-1:0]                 pc;
    logic [DEF_LANES-1:0][DEF_ILEN-1:0]  instr;
    logic [DEF_LANES-1:0]                lane_valid;
    logic                                fault;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID stage: 2-entry skid buffer with registered in_ready, flush,
// NOP fill on empty lanes, PC-alignment fault tagging and a stall counter.
module if_id_skid_stage
  import pipe_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter int              LANES     = 1,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(pipe_pkg::NOP_INSTR),
  parameter int              CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [LANES*ILEN-1:0] in_instr,
  input  logic [LANES-1:0]      in_lane_valid,
  input  logic                  in_fault,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [LANES*ILEN-1:0] out_instr,
  output logic [LANES-1:0]      out_lane_valid,
  output logic                  out_fault,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]             pc;
    logic [LANES-1:0][ILEN-1:0]  instr;
    logic [LANES-1:0]            lane_valid;
    logic                        fault;
  } pkt_t;

  occ_e state_q, state_d;
  pkt_t main_q, main_d;
  pkt_t skid_q, skid_d;
  pkt_t in_pkt;
  logic in_ready_q, in_ready_d;
  logic accept, dequeue;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign dequeue   = out_valid & out_ready;
  assign occupancy = 2'(state_q);

  always_comb begin
    in_pkt.pc         = in_pc;
    in_pkt.instr      = in_instr;
    in_pkt.lane_valid = in_lane_valid;
    in_pkt.fault      = in_fault | pc_misaligned(in_pc[1:0]);
  end

  // Flush wins over everything; a dequeue in the flush cycle still happens
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          main_d  = in_pkt;
        end
        ONE: begin
          if (accept && dequeue) begin
            main_d = in_pkt;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = in_pkt;
          end else if (dequeue) begin
            state_d = EMPTY;
          end
        end
        TWO: if (dequeue) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // out_pc keeps the last presented PC even after the entry drains
  always_comb begin
    out_pc         = main_q.pc;
    out_lane_valid = out_valid ? main_q.lane_valid : '0;
    out_fault      = out_valid & main_q.fault;
    out_instr      = '0;
    for (int k = 0; k < LANES; k++) begin
      out_instr[k*ILEN +: ILEN] = (out_valid && main_q.lane_valid[k]) ? main_q.instr[k] : NOP_INSTR;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

`ifndef SYNTHESIS
  property p_in_stable;
    @(posedge clk) disable iff (!rst_n)
      (in_valid && !in_ready && !flush) |=>
        ($stable(in_pc) && $stable(in_instr) && $stable(in_lane_valid) && $stable(in_fault));
  endproperty
  a_in_stable: assert property (p_in_stable);
  a_occ_legal: assert property (@(posedge clk) disable iff (!rst_n) occupancy != 2'd3);
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Scoreboard bench for if_id_skid_stage with LANES=2 and a 4-bit stall counter.
module tb_if_id_skid_stage;

  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int LANES = 2;
  localparam int CNT_W = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-1:0]       in_pc;
  logic [LANES*ILEN-1:0] in_instr;
  logic [LANES-1:0]      in_lane_valid;
  logic                  in_fault;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_pc;
  logic [LANES*ILEN-1:0] out_instr;
  logic [LANES-1:0]      out_lane_valid;
  logic                  out_fault;
  logic [1:0]            occupancy;
  logic [CNT_W-1:0]      stall_cnt;

  if_id_skid_stage #(
    .XLEN(XLEN), .ILEN(ILEN), .LANES(LANES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .in_lane_valid(in_lane_valid), .in_fault(in_fault),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_lane_valid(out_lane_valid), .out_fault(out_fault),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] instr;
    logic [1:0]  lv;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [63:0] instr,
                               input logic [1:0] lv, input logic f, input logic fl, input logic ordy);
    in_valid      = v;
    in_pc         = pc;
    in_instr      = instr;
    in_lane_valid = lv;
    in_fault      = f;
    flush         = fl;
    out_ready     = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a dequeue happens at the next rising edge when valid & ready at the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected: got pc %0h expected no packet", out_pc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_pc",    64'(out_pc),         64'(e.pc));
        checkOutput("sb_instr", out_instr,           e.instr);
        checkOutput("sb_lanes", 64'(out_lane_valid), 64'(e.lv));
        checkOutput("sb_fault", 64'(out_fault),      64'(e.fault));
      end
    end
  end

  initial begin
    logic [63:0] w;
    logic [31:0] pc;

    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    #2 rst_n = 1'b1;
    step();
    checkOutput("rel_in_ready",  64'(in_ready),       64'd1);
    checkOutput("rel_out_valid", 64'(out_valid),      64'd0);
    checkOutput("rel_out_instr", out_instr,           64'h00000013_00000013);
    checkOutput("rel_stall_cnt", 64'(stall_cnt),      64'd0);
    checkOutput("rel_occupancy", 64'(occupancy),      64'd0);
    checkOutput("rel_out_pc",    64'(out_pc),         64'd0);
    checkOutput("rel_lanes",     64'(out_lane_valid), 64'd0);
    checkOutput("rel_fault",     64'(out_fault),      64'd0);

    // Back-to-back stream, out_ready high
    for (int i = 0; i < 4; i++) begin
      pc = 32'h100 + 32'(i * 8);
      w  = {32'hB000_0000 | 32'(i), 32'hA000_0000 | 32'(i)};
      applyStimulus(1'b1, pc, w, 2'b11, 1'b0, 1'b0, 1'b1);
      exp_q.push_back('{pc: pc, instr: w, lv: 2'b11, fault: 1'b0});
      step();
      checkOutput("stream_valid", 64'(out_valid), 64'd1);
      checkOutput("stream_pc",    64'(out_pc),    64'(pc));
      checkOutput("stream_occ",   64'(occupancy), 64'd1);
    end
    applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("stream_drain_valid", 64'(out_valid), 64'd0);
    checkOutput("stream_drain_occ",   64'(occupancy), 64'd0);

    // Backpressure: three offered, two fit
    applyStimulus(1'b1, 32'h300, 64'h2222_0000_1111_0000, 2'b11, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('{pc: 32'h300, instr: 64'h2222_0000_1111_0000, lv: 2'b11, fault: 1'b0});
    step();
    checkOutput("bp_occ1",   64'(occupancy), 64'd1);
    checkOutput("bp_ready1", 64'(in_ready),  64'd1);
    applyStimulus(1'b1, 32'h308, 64'h2222_0001_1111_0001, 2'b11, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('{pc: 32'h308, instr: 64'h2222_0001_1111_0001, lv: 2'b11, fault: 1'b0});
    step();
    checkOutput("bp_occ2",   64'(occupancy), 64'd2);
    checkOutput("bp_ready2", 64'(in_ready),  64'd0);
    applyStimulus(1'b1, 32'h310, 64'h2222_0002_1111_0002, 2'b11, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      step();
      checkOutput("bp_hold_occ",   64'(occupancy), 64'd2);
      checkOutput("bp_hold_ready", 64'(in_ready),  64'd0);
      checkOutput("bp_hold_pc",    64'(out_pc),    64'h300);
    end
    checkOutput("bp_stall_cnt", 64'(stall_cnt), 64'd3);
    out_ready = 1'b1;
    step();
    checkOutput("bp_ready_back", 64'(in_ready),  64'd1);
    checkOutput("bp_occ_back",   64'(occupancy), 64'd1);
    checkOutput("bp_pc_skid",    64'(out_pc),    64'h308);
    exp_q.push_back('{pc: 32'h310, instr: 64'h2222_0002_1111_0002, lv: 2'b11, fault: 1'b0});
    step();
    applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("bp_drain_occ",  64'(occupancy), 64'd0);
    checkOutput("bp_stall_kept", 64'(stall_cnt), 64'd3);

    // Flush with two entries held and a packet offered
    applyStimulus(1'b1, 32'h400, 64'h4444_0000_4444_0000, 2'b11, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h408, 64'h4444_0001_4444_0001, 2'b11, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("fl_pre_occ", 64'(occupancy), 64'd2);
    applyStimulus(1'b1, 32'h200, 64'h5555_5555_5555_5555, 2'b11, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("fl_out_valid", 64'(out_valid),      64'd0);
    checkOutput("fl_occ",       64'(occupancy),      64'd0);
    checkOutput("fl_in_ready",  64'(in_ready),       64'd1);
    checkOutput("fl_lanes",     64'(out_lane_valid), 64'd0);
    checkOutput("fl_instr",     out_instr,           64'h00000013_00000013);
    checkOutput("fl_pc_held",   64'(out_pc),         64'h400);
    checkOutput("fl_stall_cnt", 64'(stall_cnt),      64'd5);
    applyStimulus(1'b1, 32'h210, 64'h6666_6666_6666_6666, 2'b11, 1'b0, 1'b1, 1'b1);
    step();
    checkOutput("fl_drop_valid", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    checkOutput("fl_idle_valid", 64'(out_valid), 64'd0);
    checkOutput("fl_stall_kept", 64'(stall_cnt), 64'd5);

    // Misaligned PC and an all-lanes-empty bubble
    applyStimulus(1'b1, 32'h102, 64'hDEAD_BEEF_1234_5678, 2'b01, 1'b0, 1'b0, 1'b1);
    exp_q.push_back('{pc: 32'h102, instr: 64'h00000013_12345678, lv: 2'b01, fault: 1'b1});
    step();
    checkOutput("al_fault", 64'(out_fault), 64'd1);
    checkOutput("al_instr", out_instr,      64'h00000013_12345678);
    applyStimulus(1'b1, 32'h120, 64'hCAFE_CAFE_CAFE_CAFE, 2'b00, 1'b1, 1'b0, 1'b1);
    exp_q.push_back('{pc: 32'h120, instr: 64'h00000013_00000013, lv: 2'b00, fault: 1'b1});
    step();
    checkOutput("bub_valid", 64'(out_valid),      64'd1);
    checkOutput("bub_lanes", 64'(out_lane_valid), 64'd0);
    checkOutput("bub_instr", out_instr,           64'h00000013_00000013);
    applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    step();

    // Saturation of the 4-bit stall counter
    applyStimulus(1'b1, 32'h500, 64'h7777_0000_7777_0000, 2'b11, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (20) step();
    checkOutput("sat_cnt",   64'(stall_cnt), 64'd15);
    checkOutput("sat_occ",   64'(occupancy), 64'd1);
    repeat (3) step();
    checkOutput("sat_cnt_hold", 64'(stall_cnt), 64'd15);
    checkOutput("sat_pc",       64'(out_pc),    64'h500);

    // Reset in the middle of operation
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_occ",   64'(occupancy), 64'd0);
    checkOutput("mid_rst_cnt",   64'(stall_cnt), 64'd0);
    checkOutput("mid_rst_pc",    64'(out_pc),    64'd0);
    checkOutput("mid_rst_ready", 64'(in_ready),  64'd1);
    exp_q.delete();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();
    checkOutput("post_rst_valid", 64'(out_valid), 64'd0);

    checkOutput("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
